// File: rtl/mem_arbiter_if.sv
// Bundle of the I-side, D-side, memory-port and status signals around the memory arbiter.
// Latency: none, this is wiring only.
// Backpressure: none here; requesters hold level requests until their done pulse.
interface mem_arbiter_if;
    // I-cache miss path
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic [15:0] i_rdata;
    // D-cache miss / writeback path
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    // unified memory port
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    // status for performance counters
    logic        busy;
    logic        owner;

    // arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, busy, owner
    );

    // requester / memory side
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache miss paths, one access in flight at a time, D preferred with an I starvation guard.
// Latency: issue one cycle after the request is sampled in IDLE; done pulses MEM_LAT+2 cycles after that sampling edge.
// Backpressure: requests are level-held and only sampled in IDLE, so a busy arbiter simply stalls the waiting requester.
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_LOAD  = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    state_t      state;
    state_t      state_nxt;

    logic        grant_vld;
    logic        grant_d;
    logic [2:0]  wait_cnt;
    logic [3:0]  starve_cnt;

    // latched access descriptor, owner doubles as the status output
    logic        owner_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] i_rdata_q;
    logic [15:0] d_rdata_q;

    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic        i_done;
    logic        d_done;
    logic        busy;

    // state register; reset aborts any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // arbitration, sequencing and strobe generation
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_d   = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.d_req && bus.i_req) begin
                    // D wins unless I has already been passed over STARVE_LIM times
                    grant_vld = 1'b1;
                    grant_d   = (starve_cnt != STARVE_MAX);
                end else if (bus.d_req) begin
                    grant_vld = 1'b1;
                    grant_d   = 1'b1;
                end else if (bus.i_req) begin
                    grant_vld = 1'b1;
                end
                if (grant_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_wr    = wr_q;
                mem_wdata = wdata_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                i_done    = ~owner_q;
                d_done    = owner_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // grant latch, starvation count, latency countdown and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant_vld) begin
                owner_q <= grant_d;
                if (grant_d) begin
                    addr_q  <= bus.d_addr;
                    wr_q    <= bus.d_wr;
                    wdata_q <= bus.d_wdata;
                    // only a D grant that actually bypassed a waiting I counts
                    if (bus.i_req && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end else begin
                    addr_q     <= bus.i_addr;
                    wr_q       <= 1'b0;
                    wdata_q    <= '0;
                    starve_cnt <= '0;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if ((state == WAIT) && (wait_cnt == 3'd0)) begin
                if (owner_q) begin
                    // writes return zero so a stale bus value never leaks out
                    d_rdata_q <= wr_q ? 16'h0000 : bus.mem_rdata;
                end else begin
                    i_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_done    = i_done;
    assign bus.d_done    = d_done;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = busy;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized requester traffic.
// Latency: expected outputs come from a transaction-level model keyed on grant cycle numbers.
// Backpressure: requesters hold req until they see done, then drop it.
module tb_mem_arbiter;
    localparam int L   = 2;
    localparam int LIM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MEM_LAT(L), .STARVE_LIM(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit in_reset;

    // transaction-level model of the current/last grant
    bit          g_act;
    int          g_cyc;
    bit          g_side;
    bit          g_wr;
    logic [15:0] g_addr;
    logic [15:0] g_wdata;
    logic [15:0] g_data;
    int          next_free;
    int          starve;

    logic [15:0] e_addr, e_irdata, e_drdata, e_wdata;
    logic        e_owner, e_busy, e_en, e_wr, e_idone, e_ddone;

    // memory responses scheduled by observed mem_en
    int          mq_due[$];
    logic [15:0] mq_dat[$];

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        if (a == 16'h0200) return 16'h1234;
        return (a ^ 16'h5A3C) + 16'h0101;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
        end
    endtask

    task automatic model_reset();
        g_act    = 1'b0;
        starve   = 0;
        e_addr   = '0;
        e_owner  = 1'b0;
        e_irdata = '0;
        e_drdata = '0;
        mq_due.delete();
        mq_dat.delete();
    endtask

    // grant decision for the edge that closes the current cycle
    task automatic decide();
        bit pick_d;
        if (in_reset || cyc < next_free) return;
        if (!bus.i_req && !bus.d_req) return;
        pick_d = bus.d_req && !(bus.i_req && starve == LIM);
        g_act  = 1'b1;
        g_cyc  = cyc;
        g_side = pick_d;
        if (pick_d) begin
            g_addr  = bus.d_addr;
            g_wr    = bus.d_wr;
            g_wdata = bus.d_wdata;
            g_data  = bus.d_wr ? 16'h0000 : mem_fn(bus.d_addr);
            if (bus.i_req && starve < LIM) starve++;
        end else begin
            g_addr  = bus.i_addr;
            g_wr    = 1'b0;
            g_wdata = 16'h0000;
            g_data  = mem_fn(bus.i_addr);
            starve  = 0;
        end
        next_free = cyc + L + 3;
    endtask

    // expected outputs for the current cycle
    task automatic model_cycle();
        e_busy  = 1'b0;
        e_en    = 1'b0;
        e_wr    = 1'b0;
        e_wdata = '0;
        e_idone = 1'b0;
        e_ddone = 1'b0;
        if (g_act && !in_reset) begin
            if (cyc >= g_cyc + 1 && cyc <= g_cyc + L + 2) e_busy = 1'b1;
            if (cyc == g_cyc + 1) begin
                e_addr  = g_addr;
                e_owner = g_side;
                e_en    = 1'b1;
                e_wr    = g_wr;
                e_wdata = g_wdata;
            end
            if (cyc == g_cyc + L + 2) begin
                if (g_side) begin
                    e_ddone  = 1'b1;
                    e_drdata = g_data;
                end else begin
                    e_idone  = 1'b1;
                    e_irdata = g_data;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("busy",      bus.busy,      e_busy);
        chk("mem_en",    bus.mem_en,    e_en);
        chk("mem_wr",    bus.mem_wr,    e_wr);
        chk("mem_addr",  bus.mem_addr,  e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("i_done",    bus.i_done,    e_idone);
        chk("d_done",    bus.d_done,    e_ddone);
        chk("i_rdata",   bus.i_rdata,   e_irdata);
        chk("d_rdata",   bus.d_rdata,   e_drdata);
        chk("owner",     bus.owner,     e_owner);
    endtask

    task automatic tick();
        decide();
        @(posedge clk);
        #1;
        cyc++;
        model_cycle();
        check_all();
        while (mq_due.size() > 0 && mq_due[0] < cyc) begin
            void'(mq_due.pop_front());
            void'(mq_dat.pop_front());
        end
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
            void'(mq_due.pop_front());
            bus.mem_rdata = mq_dat.pop_front();
        end else begin
            bus.mem_rdata = 16'($urandom);
        end
        if (bus.mem_en === 1'b1) begin
            mq_due.push_back(cyc + L);
            mq_dat.push_back(mem_fn(bus.mem_addr));
        end
        if (bus.i_done === 1'b1) bus.i_req = 1'b0;
        if (bus.d_done === 1'b1) bus.d_req = 1'b0;
    endtask

    task automatic enter_reset();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        #1;
        model_reset();
        model_cycle();
        check_all();
    endtask

    task automatic leave_reset();
        rst_n     = 1'b1;
        in_reset  = 1'b0;
        next_free = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, bus.busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, ndone, done_cyc, nwait;
        bit seq[$];

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0;
        in_reset = 1'b1;
        next_free = 0;
        model_reset();
        tick();
        tick();
        leave_reset();

        // single I read
        t0 = cyc;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        tick();
        chk("t1_en",   bus.mem_en,   1'b1);
        chk("t1_addr", bus.mem_addr, 16'h0010);
        chk("t1_wr",   bus.mem_wr,   1'b0);
        chk("t1_busy", bus.busy,     1'b1);
        tick(); tick();
        chk("t1_busy3", bus.busy, 1'b1);
        tick();
        chk("t1_idone", bus.i_done,  1'b1);
        chk("t1_rdata", bus.i_rdata, 16'hBEEF);
        tick();
        chk("t1_idle", bus.busy, 1'b0);

        // simultaneous I and D: D first
        t0 = cyc;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0200; bus.d_wdata = 16'h7777;
        repeat (4) tick();
        chk("t2_ddone", bus.d_done,  1'b1);
        chk("t2_drd",   bus.d_rdata, 16'h1234);
        chk("t2_own",   bus.owner,   1'b1);
        tick(); tick();
        chk("t2_ien",   bus.mem_en,  1'b1);
        chk("t2_iown",  bus.owner,   1'b0);
        repeat (3) tick();
        chk("t2_idone", bus.i_done,  1'b1);
        tick();

        // D write
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0300; bus.d_wdata = 16'hA5A5;
        tick();
        chk("t3_en",    bus.mem_en,    1'b1);
        chk("t3_wr",    bus.mem_wr,    1'b1);
        chk("t3_wdata", bus.mem_wdata, 16'hA5A5);
        tick();
        chk("t3_wr0",   bus.mem_wr,    1'b0);
        chk("t3_addr",  bus.mem_addr,  16'h0300);
        tick(); tick();
        chk("t3_ddone", bus.d_done,  1'b1);
        chk("t3_drd",   bus.d_rdata, 16'h0000);
        bus.d_wr = 1'b0;
        tick();

        // starvation guard: D hammering while I waits
        bus.i_req = 1'b1; bus.i_addr = 16'h0040;
        bus.d_req = 1'b1; bus.d_addr = 16'h0500;
        nwait = 0;
        while (seq.size() < 6 && nwait < 60) begin
            tick();
            nwait++;
            if (bus.mem_en === 1'b1) seq.push_back(bus.owner);
            bus.d_req = 1'b1;
            bus.i_req = 1'b1;
        end
        chk("t4_ngrants", 16'(seq.size()), 16'd6);
        if (seq.size() == 6) begin
            chk("t4_g0", seq[0], 1'b1);
            chk("t4_g1", seq[1], 1'b1);
            chk("t4_g2", seq[2], 1'b1);
            chk("t4_g3", seq[3], 1'b1);
            chk("t4_g4", seq[4], 1'b0);
            chk("t4_g5", seq[5], 1'b1);
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        wait_idle("t4_idle");
        tick();

        // reset during WAIT aborts the access
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0600;
        tick(); tick();
        chk("t5_busy_pre", bus.busy, 1'b1);
        enter_reset();
        chk("t5_busy0", bus.busy,    1'b0);
        chk("t5_own0",  bus.owner,   1'b0);
        chk("t5_addr0", bus.mem_addr, 16'h0000);
        tick(); tick();
        leave_reset();
        t1 = cyc;
        ndone = 0;
        done_cyc = -1;
        repeat (L + 4) begin
            tick();
            if (bus.d_done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
        end
        chk("t5_ndone", 16'(ndone), 16'd1);
        chk("t5_dlat",  16'(done_cyc - t1), 16'(L + 2));

        // I drops req mid-access; done still pulses, arbiter then rests
        wait_idle("t6_pre");
        t0 = cyc;
        bus.i_req = 1'b1; bus.i_addr = 16'h0070;
        tick(); tick();
        bus.i_req = 1'b0;
        tick(); tick();
        chk("t6_idone", bus.i_done, 1'b1);
        chk("t6_dlat",  16'(cyc - t0), 16'(L + 2));
        repeat (5) begin
            tick();
            chk("t6_rest", bus.busy, 1'b0);
        end

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 16'($urandom);
            end
            if (!bus.d_req && $urandom_range(0, 1) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_wr    = 1'($urandom);
                bus.d_addr  = 16'($urandom);
                bus.d_wdata = 16'($urandom);
            end
            // inputs of the side already granted must no longer matter
            if (g_act && cyc > g_cyc && cyc < g_cyc + L + 3) begin
                if (g_side) begin
                    bus.d_wr    = 1'($urandom);
                    bus.d_addr  = 16'($urandom);
                    bus.d_wdata = 16'($urandom);
                end else begin
                    bus.i_addr = 16'($urandom);
                end
            end
            tick();
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        wait_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
